// File: rtl/adder_fifo_pkg.sv
// Shared helpers for the N-operand streaming adder: output width and operand extension.
package adder_fifo_pkg;

    localparam int MAX_W = 64;

    function automatic int out_width(input int num_in, input int w);
        return w + $clog2(num_in);
    endfunction

    // Extends the low w bits of x to MAX_W, replicating bit w-1 when signedMode is set.
    function automatic logic [MAX_W-1:0] sext_or_zext(input logic [MAX_W-1:0] x,
                                                      input int w,
                                                      input bit signedMode);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sh;
        logic [MAX_W-1:0] r;
        mask = (MAX_W'(1) << w) - MAX_W'(1);
        sh   = x >> (w - 1);
        r    = x & mask;
        if (signedMode && sh[0]) r = r | ~mask;
        return r;
    endfunction

endpackage

// File: rtl/adder_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; a full FIFO refuses pushes even when popping.
module adder_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pushData,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rdPtr;
    logic [AW-1:0]               wrPtr;
    logic                        doPush;
    logic                        doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    // Storage carries no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk_i) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_adder_fifo.sv
// N-operand streaming adder: per-channel input FIFOs joined in order, summed, and queued for one consumer.
module multi_adder_fifo
    import adder_fifo_pkg::*;
#(
    parameter  int DATA_IN_WIDTH = 8,
    parameter  int NUM_IN        = 2,
    parameter  int IN_DEPTH      = 4,
    parameter  int OUT_DEPTH     = 4,
    parameter  int SIGNED        = 0,
    localparam int OUT_W         = out_width(NUM_IN, DATA_IN_WIDTH),
    localparam int OCW           = $clog2(OUT_DEPTH) + 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_IN*DATA_IN_WIDTH-1:0] in_i,
    input  logic [NUM_IN-1:0]               in_valid_i,
    output logic [NUM_IN-1:0]               in_ready_o,
    output logic [OUT_W-1:0]                out_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [OCW-1:0]                  out_count_o
);

    localparam int ICW = $clog2(IN_DEPTH) + 1;

    logic [NUM_IN-1:0][DATA_IN_WIDTH-1:0] inHead;
    logic [NUM_IN-1:0][OUT_W-1:0]         ext;
    logic [NUM_IN-1:0][ICW-1:0]           unusedInCount;
    logic [NUM_IN-1:0]                    inFull;
    logic [NUM_IN-1:0]                    inEmpty;
    logic [OUT_W-1:0]                     sum;
    logic [OUT_W-1:0]                     outHead;
    logic                                 outFull;
    logic                                 outEmpty;
    logic                                 fire;

    for (genvar k = 0; k < NUM_IN; k++) begin : gLane
        adder_sync_fifo #(.WIDTH(DATA_IN_WIDTH), .DEPTH(IN_DEPTH)) uInFifo (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .pushData (in_i[k*DATA_IN_WIDTH +: DATA_IN_WIDTH]),
            .push     (in_valid_i[k] && in_ready_o[k]),
            .pop      (fire),
            .headData (inHead[k]),
            .full     (inFull[k]),
            .empty    (inEmpty[k]),
            .count    (unusedInCount[k])
        );

        assign in_ready_o[k] = !inFull[k] && !rst_i;
        assign ext[k] = OUT_W'(sext_or_zext(MAX_W'(inHead[k]), DATA_IN_WIDTH, SIGNED != 0));
    end

    // outFull comes from the registered count, so a same-cycle output pop never enables a fire.
    assign fire = !(|inEmpty) && !outFull;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_IN; i++) sum = sum + ext[i];
    end

    adder_sync_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH)) uOutFifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pushData (sum),
        .push     (fire),
        .pop      (out_ready_i),
        .headData (outHead),
        .full     (outFull),
        .empty    (outEmpty),
        .count    (out_count_o)
    );

    assign out_valid_o = !outEmpty;
    assign out_o       = outEmpty ? '0 : outHead;

endmodule

// File: tb/tb_multi_adder_fifo.sv
// Randomized and directed bench: unsigned and signed instances share stimulus, checked against a queue model.
module tb_multi_adder_fifo;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int OW = 10;

    logic          clk;
    logic          rst;
    logic [N*W-1:0] inData;
    logic [N-1:0]  inVld;
    logic          outRdy;
    logic [N-1:0]  inRdyU, inRdyS;
    logic [OW-1:0] outU, outS;
    logic          outVldU, outVldS;
    logic [2:0]    cntU, cntS;

    multi_adder_fifo #(.DATA_IN_WIDTH(W), .NUM_IN(N), .IN_DEPTH(4), .OUT_DEPTH(4), .SIGNED(0)) uDutU (
        .clk_i(clk), .rst_i(rst), .in_i(inData), .in_valid_i(inVld), .in_ready_o(inRdyU),
        .out_o(outU), .out_valid_o(outVldU), .out_ready_i(outRdy), .out_count_o(cntU));

    multi_adder_fifo #(.DATA_IN_WIDTH(W), .NUM_IN(N), .IN_DEPTH(4), .OUT_DEPTH(4), .SIGNED(1)) uDutS (
        .clk_i(clk), .rst_i(rst), .in_i(inData), .in_valid_i(inVld), .in_ready_o(inRdyS),
        .out_o(outS), .out_valid_o(outVldS), .out_ready_i(outRdy), .out_count_o(cntS));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int popCnt   = 0;
    int gapPct   = 0;
    bit rdyRand  = 1'b0;
    int srcQ[N][$];
    int refQ[N][$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            inVld[k] = (srcQ[k].size() > 0) && ($urandom_range(99) >= gapPct);
            inData[k*W +: W] = (srcQ[k].size() > 0) ? W'(srcQ[k][0]) : W'(0);
        end
        if (rdyRand) outRdy = $urandom_range(1) == 1;
    endtask

    task automatic checkPop();
        int have = 1;
        int su = 0;
        int ss = 0;
        for (int k = 0; k < N; k++) if (refQ[k].size() == 0) have = 0;
        chk("have", have, 1);
        if (have == 1) begin
            for (int k = 0; k < N; k++) begin
                int v = refQ[k].pop_front();
                su += v;
                ss += (v >= 128) ? v - 256 : v;
            end
            chk("sumU", 32'(outU), su & 'h3FF);
            chk("vldS", 32'(outVldS), 1);
            chk("sumS", 32'(outS), ss & 'h3FF);
        end
        popCnt++;
    endtask

    // One clock: drive at negedge, sample handshakes 1 time unit later, advance to next negedge.
    task automatic cycle();
        drive();
        #1;
        if (rst) begin
            for (int k = 0; k < N; k++) refQ[k].delete();
        end else begin
            for (int k = 0; k < N; k++)
                if (inVld[k] && inRdyU[k]) refQ[k].push_back(srcQ[k].pop_front());
            if (outVldU && outRdy) checkPop();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit idle();
        bit r = !outVldU;
        for (int k = 0; k < N; k++) if (srcQ[k].size() != 0 || refQ[k].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input int maxCyc);
        int n = 0;
        while (!idle() && n < maxCyc) begin
            cycle();
            n++;
        end
        chk("drainTO", 32'(n < maxCyc), 1);
    endtask

    task automatic pushSet(input int a, input int b, input int c);
        srcQ[0].push_back(a);
        srcQ[1].push_back(b);
        srcQ[2].push_back(c);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int base;
        bit rdyHeld;
        rst = 1'b1; inVld = '0; inData = '0; outRdy = 1'b0;
        @(negedge clk);
        repeat (2) cycle();
        chk("rstRdy", 32'(inRdyU), 0);
        rst = 1'b0;
        #1;
        chk("relRdy", 32'(inRdyU), 3'b111);
        chk("relVld", 32'(outVldU), 0);
        chk("relCnt", 32'(cntU), 0);
        chk("relOut", 32'(outU), 0);
        @(negedge clk);

        // 255 x3: latency and unsigned/signed sums
        outRdy = 1'b1;
        pushSet(255, 255, 255);
        cycle();
        chk("lat1", 32'(outVldU), 0);
        cycle();
        chk("lat2", 32'(outVldU), 1);
        chk("u765", 32'(outU), 'h2FD);
        chk("sM3", 32'(outS), 'h3FD);
        drain(20);

        // 0x80 x3, then 7F/80/01
        pushSet('h80, 'h80, 'h80);
        pushSet('h7F, 'h80, 'h01);
        cycle();
        cycle();
        chk("s80", 32'(outS), 'h280);
        chk("u80", 32'(outU), 'h180);
        cycle();
        chk("s0", 32'(outS), 0);
        chk("u100", 32'(outU), 'h100);
        drain(20);

        // skewed arrival on channel 0 only
        for (int i = 1; i <= 4; i++) srcQ[0].push_back(i);
        repeat (4) cycle();
        chk("skRdy", 32'(inRdyU), 3'b110);
        chk("skNoOut", 32'(outVldU), 0);
        base = popCnt;
        for (int i = 1; i <= 4; i++) begin
            srcQ[1].push_back(10 * i);
            srcQ[2].push_back(0);
        end
        drain(40);
        chk("skPops", popCnt - base, 4);

        // backpressure: 10 sets with consumer stalled
        outRdy = 1'b0;
        base = popCnt;
        for (int i = 0; i < 10; i++)
            pushSet($urandom_range(255), $urandom_range(255), $urandom_range(255));
        repeat (12) cycle();
        chk("bpCnt", 32'(cntU), 4);
        chk("bpRdy", 32'(inRdyU), 0);
        chk("bpLeft", srcQ[0].size(), 2);
        outRdy = 1'b1;
        drain(60);
        chk("bpPops", popCnt - base, 10);

        // reset mid-stream
        outRdy = 1'b0;
        for (int i = 0; i < 3; i++) pushSet(100 + i, 50, 7);
        srcQ[0].push_back(1);
        srcQ[0].push_back(2);
        repeat (8) cycle();
        chk("preCnt", 32'(cntU), 3);
        chk("preLeft", srcQ[0].size(), 0);
        rst = 1'b1;
        cycle();
        chk("rstRdy2", 32'(inRdyU), 0);
        rst = 1'b0;
        #1;
        chk("postVld", 32'(outVldU), 0);
        chk("postCnt", 32'(cntU), 0);
        chk("postRdy", 32'(inRdyU), 3'b111);
        @(negedge clk);
        base = popCnt;
        outRdy = 1'b1;
        pushSet(5, 6, 7);
        drain(20);
        chk("postPops", popCnt - base, 1);

        // full rate: one sum per cycle after the 2-cycle fill
        base = popCnt;
        rdyHeld = 1'b1;
        for (int i = 0; i < 20; i++)
            pushSet($urandom_range(255), $urandom_range(255), $urandom_range(255));
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (inRdyU != 3'b111) rdyHeld = 1'b0;
        end
        chk("frPops", popCnt - base, 20);
        chk("frRdy", 32'(rdyHeld), 1);

        // random gaps and random backpressure
        base = popCnt;
        gapPct = 30;
        rdyRand = 1'b1;
        for (int i = 0; i < 300; i++)
            pushSet($urandom_range(255), $urandom_range(255), $urandom_range(255));
        drain(5000);
        chk("rndPops", popCnt - base, 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_adder_fifo.md
# multi_adder_fifo

Parametrised N-operand streaming adder with per-operand input FIFOs and an output FIFO. It generalises the two-operand adder-with-FIFO to NUM_IN channels, configurable depths and signed/unsigned arithmetic. Operands arrive independently on valid/ready channels and are joined in order, one from each channel. Sums leave on a single valid/ready output. It sits between independent producers and a single consumer in the adder example datapath.

## Interface
Reset is synchronous and active-high; the block has one clock.

Parameters:
- DATA_IN_WIDTH, 8: width of each operand.
- NUM_IN, 2: operand channel count; legal range 2..16.
- IN_DEPTH, 4: entries per input FIFO; must be a power of two, at least 2.
- OUT_DEPTH, 4: entries in the output FIFO; must be a power of two, at least 2.
- SIGNED, 0: 0 treats operands as unsigned (zero-extended); 1 treats them as two's complement (sign-extended).

Ports (OUT_W = DATA_IN_WIDTH + $clog2(NUM_IN)):
- clk_i, input, 1: clock; all logic on the rising edge.
- rst_i, input, 1: synchronous active-high reset.
- in_i, input, NUM_IN*DATA_IN_WIDTH: operands packed; channel k occupies bits [k*W +: W].
- in_valid_i, input, NUM_IN: per-channel valid.
- in_ready_o, output, NUM_IN: per-channel ready.
- out_o, output, OUT_W: sum at the head of the output FIFO.
- out_valid_o, output, 1: output FIFO is non-empty.
- out_ready_i, input, 1: consumer accepts the output.
- out_count_o, output, $clog2(OUT_DEPTH)+1: output FIFO occupancy.

## Operation
- Channel k push: in_valid_i[k] && in_ready_o[k]. Channels are fully independent.
- in_ready_o[k] = !full_k && !rst_i. There is no bypass; a full FIFO never accepts a word, even if it pops in the same cycle.
- Join fires when all input FIFOs are non-empty and out_count < OUT_DEPTH. On a fire:
  - every input FIFO pops its head in the same cycle;
  - the sum of all heads, each extended to OUT_W, is written to the output FIFO.
- The join decision uses the registered out_count, so a pop in the same cycle does not free a slot for that cycle's fire.
- Width rule: OUT_W never overflows for NUM_IN operands. Arithmetic is modulo 2^OUT_W, which is exact in both modes.
- Output pop: out_valid_o && out_ready_i. Push and pop in the same cycle leave out_count unchanged.
- Ordering: output n is the sum of the n-th word accepted on every channel.
- Reset, including mid-operation:
  - all FIFO pointers and counts clear to 0;
  - in-flight data is discarded;
  - out_valid_o = 0, out_o = 0, out_count_o = 0;
  - in_ready_o = 0 while rst_i is high, and all ones in the first cycle after release.

## Timing
- Input FIFO: a word pushed at edge t is visible at its head after edge t.
- Join is registered. With all other FIFOs non-empty and the output not full, the last operand pushed at edge t fires at edge t+1, and out_valid_o is high after edge t+1.
- Minimum input-to-output latency is 2 cycles.
- Throughput is 1 sum per cycle while all channels supply and out_ready_i is held high, given OUT_DEPTH ≥ 2.
- out_o is held stable while out_valid_o && !out_ready_i.
- in_ready_o[k] drops in the cycle after the push that fills FIFO k.

## Structure
- Package adder_fifo_pkg holds:
  - function out_width(num_in, w), returning w + $clog2(num_in);
  - function sext_or_zext, for operand extension under SIGNED.
- Sub-module adder_sync_fifo #(WIDTH, DEPTH):
  - circular buffer with read/write pointers and a count;
  - outputs full, empty and count.
- This FIFO is instantiated NUM_IN times for the inputs and once for the output. The top level contains only the join logic and the adder tree.

## Test plan
- NUM_IN=3, W=8, SIGNED=0: push 255 on every channel, out_ready_i=1. Required: out_o = 10'h2FD (765) with out_valid_o high 2 cycles after the last push.
- SIGNED=1, NUM_IN=3, W=8: push 8'h80 on all channels. Required: out_o = 10'h280 (−384). Then push 8'h7F, 8'h80, 8'h01. Required: out_o = 10'h000.
- Skewed arrival, NUM_IN=2, IN_DEPTH=4: push 1,2,3,4 on channel 0 only. Required: in_ready_o[0] = 0 after the 4th push, and no output. Then push 10,20,30,40 on channel 1. Required outputs in order: 11, 22, 33, 44.
- Backpressure, OUT_DEPTH=4, out_ready_i=0: stream 10 operand sets. Required: out_count_o saturates at 4, the input FIFOs fill, and all in_ready_o drop. Then release out_ready_i. Required: all 10 sums emerge in order with no loss or duplication.
- Reset mid-stream: with out_count_o=3 and input FIFOs partially full, assert rst_i for 1 cycle. Required: out_valid_o = 0 and out_count_o = 0, in_ready_o all ones on the next cycle, and none of the stale sums appear afterwards.
- Full-rate, NUM_IN=4, SIGNED=0: drive random operands every cycle with out_ready_i=1. Required: one sum per cycle after the 2-cycle fill, each matching the reference model.
